sobel_frame_ctrl: RTL and testbench

- Sequences a full-frame Sobel pass.
- Reads an H x W 8-bit greyscale frame from a single-port synchronous frame memory, one pixel per cycle.
- Assembles row-major 3x3 windows for the sobel datapath (win0 = top-left … win8 = bottom-right) and pulses win_valid once per window.
- Captures the datapath result a fixed LAT cycles later and writes it to a result memory at sequential addresses.
- Owns start/busy/done for the frame; sits between the frame buffer, the sobel datapath and the result buffer.

---
 rtl/sobel_frame_ctrl_if.sv | 32 +++
 rtl/sobel_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_frame_ctrl_if.sv
// Bundle between the Sobel frame controller and its environment: control,
// frame-memory read port, window output and result-memory write port.
interface sobel_frame_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic              win_valid;
  logic [7:0]        res_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    input  start, rd_data, res_in,
    output busy, done, rd_en, rd_addr,
           win0, win1, win2, win3, win4, win5, win6, win7, win8,
           win_valid, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data, res_in,
    input  busy, done, rd_en, rd_addr,
           win0, win1, win2, win3, win4, win5, win6, win7, win8,
           win_valid, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Full-frame Sobel sequencer: streams 3x3 windows from the frame memory to the
// datapath and writes the delayed datapath results to the result memory.
module sobel_frame_ctrl #(
  parameter int H      = 391,
  parameter int W      = 317,
  parameter int ADDR_W = 17,
  parameter int LAT    = 2
) (
  input  logic               clk,
  input  logic               rstn,
  sobel_frame_ctrl_if.master bus
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam logic [ADDR_W-1:0] W1_A = ADDR_W'(W);
  localparam logic [ADDR_W-1:0] W2_A = ADDR_W'(2 * W);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t            state, state_nx;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col, col_d;
  logic [1:0]        k, k_d;
  logic [ADDR_W-1:0] base, rd_addr, res_cnt;
  logic              rd_vld_d, win_valid;
  logic [7:0]        colbuf [2];
  logic [7:0]        win    [9];
  logic [LAT-1:0]    vsr, vsr_early;
  logic              last_rd, pending, busy, done, rd_en;

  assign last_rd = (row == RW'(H - 3)) && (col == CW'(W - 1)) && (k == 2'd2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    // Anything still in flight other than the write happening this cycle.
    vsr_early = vsr;
    vsr_early[LAT-1] = 1'b0;
    pending   = rd_vld_d | win_valid | (|vsr_early);
    case (state)
      IDLE:  if (bus.start) state_nx = FETCH;
      FETCH: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        case (k)
          2'd0:    rd_addr = base;
          2'd1:    rd_addr = base + W1_A;
          default: rd_addr = base + W2_A;
        endcase
        if (last_rd) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!pending) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row       <= '0;
      col       <= '0;
      k         <= '0;
      base      <= '0;
      rd_vld_d  <= 1'b0;
      k_d       <= '0;
      col_d     <= '0;
      win_valid <= 1'b0;
      vsr       <= '0;
      res_cnt   <= '0;
      colbuf[0] <= '0;
      colbuf[1] <= '0;
      for (int unsigned i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        row     <= '0;
        col     <= '0;
        k       <= '0;
        base    <= '0;
        res_cnt <= '0;
      end else if (state == FETCH) begin
        // base tracks row*W + col, so a row wrap is just another increment.
        if (k == 2'd2) begin
          k    <= '0;
          base <= base + 1'b1;
          if (col == CW'(W - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end else begin
          k <= k + 1'b1;
        end
      end

      rd_vld_d <= (state == FETCH);
      k_d      <= k;
      col_d    <= col;

      if (rd_vld_d) begin
        if (k_d != 2'd2) begin
          colbuf[k_d[0]] <= bus.rd_data;
        end else begin
          for (int unsigned i = 0; i < 3; i++) begin
            win[3*i]   <= win[3*i+1];
            win[3*i+1] <= win[3*i+2];
          end
          win[2] <= colbuf[0];
          win[5] <= colbuf[1];
          win[8] <= bus.rd_data;
        end
      end

      win_valid <= rd_vld_d && (k_d == 2'd2) && (col_d >= CW'(2));
      vsr       <= (vsr << 1) | LAT'(win_valid);
      if (vsr[LAT-1]) res_cnt <= res_cnt + 1'b1;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_addr;
  assign bus.win0      = win[0];
  assign bus.win1      = win[1];
  assign bus.win2      = win[2];
  assign bus.win3      = win[3];
  assign bus.win4      = win[4];
  assign bus.win5      = win[5];
  assign bus.win6      = win[6];
  assign bus.win7      = win[7];
  assign bus.win8      = win[8];
  assign bus.win_valid = win_valid;
  assign bus.wr_en     = vsr[LAT-1];
  assign bus.wr_addr   = res_cnt;
  assign bus.wr_data   = vsr[LAT-1] ? bus.res_in : '0;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: two instances (5x5/LAT2 and 3x3/LAT1) traced
// cycle by cycle against a frame-level reference model.
module tb_sobel_frame_ctrl;
  localparam int NC = 128;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [16:0]      rd_addr;
    logic             win_valid;
    logic [8:0][7:0]  win;
    logic             wr_en;
    logic [16:0]      wr_addr;
    logic [7:0]       wr_data;
  } snap_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sobel_frame_ctrl_if #(.ADDR_W(17)) ifa ();
  sobel_frame_ctrl_if #(.ADDR_W(17)) ifb ();

  sobel_frame_ctrl #(.H(5), .W(5), .ADDR_W(17), .LAT(2)) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa)
  );
  sobel_frame_ctrl #(.H(3), .W(3), .ADDR_W(17), .LAT(1)) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb)
  );

  // Frame memory and datapath models (datapath result = win4 ^ 8'hFF).
  logic [7:0] img [64];
  logic [7:0] dpa [2];
  logic [7:0] dpb;
  always @(posedge clk) if (ifa.rd_en) ifa.rd_data <= img[ifa.rd_addr[5:0]];
  always @(posedge clk) if (ifb.rd_en) ifb.rd_data <= img[ifb.rd_addr[5:0]];
  always @(posedge clk) begin
    dpa[0] <= ifa.win4 ^ 8'hFF;
    dpa[1] <= dpa[0];
    dpb    <= ifb.win4 ^ 8'hFF;
  end
  assign ifa.res_in = dpa[1];
  assign ifb.res_in = dpb;

  snap_t sa, sb, cur;
  bit    sel;
  assign sa = {ifa.busy, ifa.done, ifa.rd_en, ifa.rd_addr, ifa.win_valid,
               {ifa.win8, ifa.win7, ifa.win6, ifa.win5, ifa.win4,
                ifa.win3, ifa.win2, ifa.win1, ifa.win0},
               ifa.wr_en, ifa.wr_addr, ifa.wr_data};
  assign sb = {ifb.busy, ifb.done, ifb.rd_en, ifb.rd_addr, ifb.win_valid,
               {ifb.win8, ifb.win7, ifb.win6, ifb.win5, ifb.win4,
                ifb.win3, ifb.win2, ifb.win1, ifb.win0},
               ifb.wr_en, ifb.wr_addr, ifb.wr_data};
  assign cur = sel ? sb : sa;

  int total = 0;
  int bad   = 0;

  snap_t           log_s [NC];
  logic [4:0]      e_strb [NC];  // {rd_en, busy, done, win_valid, wr_en}
  logic [16:0]     e_rd_addr [NC];
  logic [16:0]     e_wr_addr [NC];
  logic [8:0][7:0] e_win [NC];
  logic [7:0]      e_wr_data [NC];
  int              e_reads, e_writes;

  task automatic build_model(input int h, input int w, input int lat);
    int t, n, dc;
    logic [8:0][7:0] wv;
    for (int i = 0; i < NC; i++) begin
      e_strb[i] = '0; e_rd_addr[i] = '0; e_wr_addr[i] = '0;
      e_win[i] = '0; e_wr_data[i] = '0;
    end
    for (int r = 0; r < h - 2; r++)
      for (int c = 0; c < w; c++)
        for (int k = 0; k < 3; k++) begin
          t = 3*w*r + 3*c + k;
          e_strb[t][4] = 1'b1;
          e_rd_addr[t] = 17'((r + k) * w + c);
        end
    n = 0;
    dc = 0;
    for (int r = 0; r < h - 2; r++)
      for (int c = 2; c < w; c++) begin
        t = 3*w*r + 3*c + 4;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) wv[i*3+j] = img[(r + i) * w + c - 2 + j];
        e_strb[t][1] = 1'b1;
        e_win[t] = wv;
        e_strb[t+lat][0] = 1'b1;
        e_wr_addr[t+lat] = 17'(n);
        e_wr_data[t+lat] = wv[4] ^ 8'hFF;
        n++;
        dc = t + lat + 1;
      end
    e_strb[dc][2] = 1'b1;
    for (int i = 0; i < dc; i++) e_strb[i][3] = 1'b1;
    e_reads  = 3 * w * (h - 2);
    e_writes = n;
  endtask

  task automatic launch(input bit use_b, input bit hold, input int ncyc);
    sel = use_b;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    if (use_b) ifb.start = 1'b1; else ifa.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin ifa.start = 1'b0; ifb.start = 1'b0; end
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      log_s[n] = cur;
      if (hold && cur.done) begin ifa.start = 1'b0; ifb.start = 1'b0; end
    end
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (sa !== '0) begin bad++; $display("FAIL reset_a: got %h expected 0", sa); end
    total++;
    if (sb !== '0) begin bad++; $display("FAIL reset_b: got %h expected 0", sb); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_window;
    logic [8:0][7:0] ew;
    int exp_w [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    for (int i = 0; i < 64; i++) img[i] = 8'(i);
    for (int i = 0; i < 9; i++) ew[i] = 8'(exp_w[i]);
    launch(1'b0, 1'b0, 70);
    total++;
    if ({log_s[0].rd_en, log_s[0].busy, log_s[0].rd_addr} !== {2'b11, 17'd0}) begin
      bad++; $display("FAIL cycle0: got rd_en=%b busy=%b addr=%0d expected 1 1 0",
                      log_s[0].rd_en, log_s[0].busy, log_s[0].rd_addr);
    end
    total++;
    if (log_s[9].win_valid !== 1'b0 || log_s[10].win_valid !== 1'b1) begin
      bad++; $display("FAIL first_wv: got c9=%b c10=%b expected 0 1",
                      log_s[9].win_valid, log_s[10].win_valid);
    end
    total++;
    if (log_s[10].win !== ew) begin
      bad++; $display("FAIL first_win: got %h expected %h", log_s[10].win, ew);
    end
    total++;
    if ({log_s[12].wr_en, log_s[12].wr_addr, log_s[12].wr_data} !== {1'b1, 17'd0, 8'hF9}) begin
      bad++; $display("FAIL first_wr: got en=%b addr=%0d data=%h expected 1 0 f9",
                      log_s[12].wr_en, log_s[12].wr_addr, log_s[12].wr_data);
    end
  endtask

  task automatic test_row_start;
    logic [8:0][7:0] ew;
    int exp_w [9] = '{5, 6, 7, 10, 11, 12, 15, 16, 17};
    for (int i = 0; i < 64; i++) img[i] = 8'(i);
    for (int i = 0; i < 9; i++) ew[i] = 8'(exp_w[i]);
    launch(1'b0, 1'b0, 70);
    total++;
    if (log_s[25].win_valid !== 1'b1 || log_s[25].win !== ew) begin
      bad++; $display("FAIL row1_win: got wv=%b win=%h expected 1 %h",
                      log_s[25].win_valid, log_s[25].win, ew);
    end
    total++;
    if ({log_s[19].win_valid, log_s[22].win_valid, log_s[34].win_valid, log_s[37].win_valid} !== 4'b0) begin
      bad++; $display("FAIL row_refill: got %b expected 0000",
                      {log_s[19].win_valid, log_s[22].win_valid, log_s[34].win_valid, log_s[37].win_valid});
    end
    total++;
    if ({log_s[48].wr_en, log_s[48].wr_addr, log_s[49].done, log_s[49].busy, log_s[50].done}
        !== {1'b1, 17'd8, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL done_pulse: got wr_en=%b addr=%0d done=%b busy=%b next_done=%b expected 1 8 1 0 0",
                      log_s[48].wr_en, log_s[48].wr_addr, log_s[49].done, log_s[49].busy, log_s[50].done);
    end
  endtask

  // Scenarios: addr image; random image with start held; random back-to-back
  // pass; random image on the 3x3 instance.
  task automatic test_full_frame;
    logic [4:0] act;
    int nrd, nwr;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 64; i++) img[i] = (s == 0) ? 8'(i) : 8'($urandom);
      if (s == 3) build_model(3, 3, 1); else build_model(5, 5, 2);
      launch(s == 3, s == 1, 70);
      nrd = 0;
      nwr = 0;
      for (int n = 0; n < 70; n++) begin
        act = {log_s[n].rd_en, log_s[n].busy, log_s[n].done, log_s[n].win_valid, log_s[n].wr_en};
        total++;
        if (act !== e_strb[n]) begin
          bad++; $display("FAIL strobes s%0d c%0d: got %b expected %b", s, n, act, e_strb[n]);
        end
        if (e_strb[n][4]) begin
          total++;
          if (log_s[n].rd_addr !== e_rd_addr[n]) begin
            bad++; $display("FAIL rd_addr s%0d c%0d: got %0d expected %0d", s, n, log_s[n].rd_addr, e_rd_addr[n]);
          end
        end
        if (e_strb[n][1]) begin
          total++;
          if (log_s[n].win !== e_win[n]) begin
            bad++; $display("FAIL window s%0d c%0d: got %h expected %h", s, n, log_s[n].win, e_win[n]);
          end
        end
        if (e_strb[n][0]) begin
          total++;
          if ({log_s[n].wr_addr, log_s[n].wr_data} !== {e_wr_addr[n], e_wr_data[n]}) begin
            bad++; $display("FAIL write s%0d c%0d: got addr=%0d data=%h expected %0d %h",
                            s, n, log_s[n].wr_addr, log_s[n].wr_data, e_wr_addr[n], e_wr_data[n]);
          end
        end
        nrd += int'(log_s[n].rd_en);
        nwr += int'(log_s[n].wr_en);
      end
      total++;
      if (nrd !== e_reads || nwr !== e_writes) begin
        bad++; $display("FAIL totals s%0d: got reads=%0d writes=%0d expected %0d %0d",
                        s, nrd, nwr, e_reads, e_writes);
      end
    end
  endtask

  task automatic test_async_reset;
    int cnt;
    sel = 1'b0;
    @(negedge clk);
    ifa.start = 1'b1;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    repeat (21) @(negedge clk);
    total++;
    if (sa.busy !== 1'b1) begin bad++; $display("FAIL pre_reset_busy: got %b expected 1", sa.busy); end
    #2 rstn = 1'b0;
    #1;
    total++;
    if (sa !== '0) begin bad++; $display("FAIL async_clear: got %h expected 0", sa); end
    @(negedge clk);
    rstn = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (sa.rd_en || sa.wr_en || sb.rd_en || sb.wr_en) cnt++;
    end
    total++;
    if (cnt !== 0) begin bad++; $display("FAIL post_reset_quiet: got %0d strobe cycles expected 0", cnt); end
  endtask

  task automatic test_small;
    logic [8:0][7:0] ew;
    int nrd;
    for (int i = 0; i < 64; i++) img[i] = 8'(i);
    for (int i = 0; i < 9; i++) ew[i] = 8'(i);
    launch(1'b1, 1'b0, 40);
    nrd = 0;
    for (int n = 0; n < 40; n++) nrd += int'(log_s[n].rd_en);
    total++;
    if (nrd !== 9) begin bad++; $display("FAIL small_reads: got %0d expected 9", nrd); end
    total++;
    if (log_s[10].win_valid !== 1'b1 || log_s[10].win !== ew) begin
      bad++; $display("FAIL small_win: got wv=%b win=%h expected 1 %h", log_s[10].win_valid, log_s[10].win, ew);
    end
    total++;
    if ({log_s[11].wr_en, log_s[11].wr_addr, log_s[11].wr_data, log_s[12].done} !== {1'b1, 17'd0, 8'hFB, 1'b1}) begin
      bad++; $display("FAIL small_wr_done: got en=%b addr=%0d data=%h done=%b expected 1 0 fb 1",
                      log_s[11].wr_en, log_s[11].wr_addr, log_s[11].wr_data, log_s[12].done);
    end
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    sel = 1'b0;
    test_reset();
    test_first_window();
    test_row_start();
    test_full_frame();
    test_async_reset();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
